uart_echo_tester: RTL and testbench

Self-checking initiator for the UART loopback path: drives a deterministic byte pattern into a `uart_send` instance and checks each byte echoed back through a `uart_recv` instance against the expected value. It sits on the host/tester side of the link, opposite the board-side loopback (`recv` → loop → `send`). It reports per-run byte count, error count and pass/fail for board bring-up and the PL test set.

---
 rtl/uart_echo_tester_if.sv | 26 ++
 rtl/uart_echo_tester.sv | 128 ++++++++++++
 tb/tb_uart_echo_tester.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_echo_tester_if.sv
// Tester-side bundle: run control/status plus the uart_send / uart_recv handshake.
// master = the tester core, slave = the surrounding board/bench logic.
interface uart_echo_tester_if;
  logic        start;
  logic        tx_busy;
  logic        send_en;
  logic [7:0]  send_data;
  logic        recv_done;
  logic [7:0]  recv_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  err_cnt;
  logic [15:0] byte_cnt;
  logic        timeout_seen;

  modport master (
    input  start, tx_busy, recv_done, recv_data,
    output send_en, send_data, busy, done, pass, err_cnt, byte_cnt, timeout_seen
  );

  modport slave (
    output start, tx_busy, recv_done, recv_data,
    input  send_en, send_data, busy, done, pass, err_cnt, byte_cnt, timeout_seen
  );
endinterface

// File: rtl/uart_echo_tester.sv
// UART loopback initiator: sends SEED+k, checks each echo, counts errors/timeouts.
// Strobe one cycle after start; next byte waits for echo (or timeout) and tx_busy low.
module uart_echo_tester #(
  parameter int unsigned NUM_BYTES   = 16,
  parameter logic [7:0]  SEED        = 8'h00,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_echo_tester_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ECHO,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic [15:0] LP_NUM_BYTES = NUM_BYTES[15:0];
  localparam logic [31:0] LP_TIMEOUT   = TIMEOUT_CYC[31:0];

  state_t      r_state;
  logic [31:0] r_tmo_cnt;
  logic        r_send_en;
  logic [7:0]  r_send_data;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [7:0]  r_err_cnt;
  logic [15:0] r_byte_cnt;
  logic        r_timeout_seen;

  logic [31:0] w_tmo_nxt;
  logic        w_tmo_hit;
  logic [7:0]  w_err_inc;
  logic        w_last_byte;

  // The counter holds the number of completed wait cycles, so the
  // TIMEOUT_CYC-th cycle after SEND is the one where the next value hits the limit.
  assign w_tmo_nxt   = r_tmo_cnt + 32'd1;
  assign w_tmo_hit   = (w_tmo_nxt == LP_TIMEOUT);
  assign w_err_inc   = (r_err_cnt == 8'hFF) ? r_err_cnt : (r_err_cnt + 8'd1);
  assign w_last_byte = (r_byte_cnt == LP_NUM_BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_tmo_cnt      <= '0;
      r_send_en      <= 1'b0;
      r_send_data    <= 8'h00;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_err_cnt      <= '0;
      r_byte_cnt     <= '0;
      r_timeout_seen <= 1'b0;
    end else begin
      r_send_en <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_err_cnt      <= '0;
            r_byte_cnt     <= '0;
            r_timeout_seen <= 1'b0;
            r_pass         <= 1'b0;
            r_send_data    <= SEED;
            r_busy         <= 1'b1;
            r_send_en      <= 1'b1;
            r_state        <= ST_SEND;
          end
        end
        ST_SEND: begin
          r_tmo_cnt <= '0;
          r_state   <= ST_WAIT_ECHO;
        end
        ST_WAIT_ECHO: begin
          r_tmo_cnt <= w_tmo_nxt;
          // An echo landing on the limit cycle takes priority over the timeout.
          if (bus.recv_done) begin
            if (bus.recv_data != r_send_data) begin
              r_err_cnt <= w_err_inc;
            end
            r_byte_cnt <= r_byte_cnt + 16'd1;
            r_state    <= ST_GAP;
          end else if (w_tmo_hit) begin
            r_err_cnt      <= w_err_inc;
            r_timeout_seen <= 1'b1;
            r_byte_cnt     <= r_byte_cnt + 16'd1;
            r_state        <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (!bus.tx_busy) begin
            if (w_last_byte) begin
              r_done  <= 1'b1;
              r_pass  <= (r_err_cnt == 8'd0);
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_send_data <= r_send_data + 8'd1;
              r_send_en   <= 1'b1;
              r_state     <= ST_SEND;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.send_en      = r_send_en;
  assign bus.send_data    = r_send_data;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.pass         = r_pass;
  assign bus.err_cnt      = r_err_cnt;
  assign bus.byte_cnt     = r_byte_cnt;
  assign bus.timeout_seen = r_timeout_seen;

endmodule

// File: tb/tb_uart_echo_tester.sv
// Bench for uart_echo_tester: two instances (SEED 41 / FE) behind a shared echo model.
// The model replays each sent byte after a per-byte delay and holds tx_busy for a per-byte length.
module tb_uart_echo_tester;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_echo_tester_if bus_a ();
  uart_echo_tester_if bus_b ();

  uart_echo_tester #(.NUM_BYTES(4), .SEED(8'h41), .TIMEOUT_CYC(100)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.master)
  );
  uart_echo_tester #(.NUM_BYTES(4), .SEED(8'hFE), .TIMEOUT_CYC(20000)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.master)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  int         sel = 0;
  int         dly  [4];
  int         blen [4];
  bit         corr_en [4];
  logic [7:0] corr_val[4];
  logic [7:0] sent [8];
  int         send_cyc [8];
  int         n_sent = 0;
  int         echo_cd = 0;
  int         busy_cd = 0;
  logic [7:0] echo_byte = 8'h00;
  int         cyc = 0;
  int         done_cnt = 0;

  logic       m_recv_done = 1'b0;
  logic       m_tx_busy   = 1'b0;
  logic [7:0] m_recv_data = 8'h00;

  assign bus_a.recv_done = (sel == 0) ? m_recv_done : 1'b0;
  assign bus_a.recv_data = m_recv_data;
  assign bus_a.tx_busy   = (sel == 0) ? m_tx_busy : 1'b0;
  assign bus_b.recv_done = (sel == 1) ? m_recv_done : 1'b0;
  assign bus_b.recv_data = m_recv_data;
  assign bus_b.tx_busy   = (sel == 1) ? m_tx_busy : 1'b0;

  wire       w_send_en   = (sel == 1) ? bus_b.send_en   : bus_a.send_en;
  wire [7:0] w_send_data = (sel == 1) ? bus_b.send_data : bus_a.send_data;
  wire       w_done      = (sel == 1) ? bus_b.done      : bus_a.done;

  always @(negedge clk) begin
    int idx;
    cyc = cyc + 1;
    if (w_done) done_cnt = done_cnt + 1;
    m_recv_done = 1'b0;
    if (echo_cd > 0) begin
      echo_cd = echo_cd - 1;
      if (echo_cd == 0) begin
        m_recv_done = 1'b1;
        m_recv_data = echo_byte;
      end
    end
    if (busy_cd > 0) busy_cd = busy_cd - 1;
    m_tx_busy = (busy_cd > 0);
    if (w_send_en) begin
      idx = (n_sent < 4) ? n_sent : 3;
      if (n_sent < 8) begin
        sent[n_sent]     = w_send_data;
        send_cyc[n_sent] = cyc;
      end
      echo_byte = corr_en[idx] ? corr_val[idx] : w_send_data;
      echo_cd   = dly[idx];
      busy_cd   = blen[idx];
      m_tx_busy = 1'b1;
      n_sent    = n_sent + 1;
    end
  end

  task automatic model_clear();
    n_sent   = 0;
    echo_cd  = 0;
    busy_cd  = 0;
    done_cnt = 0;
  endtask

  task automatic cfg_ideal();
    for (int i = 0; i < 4; i++) begin
      dly[i]      = 50;
      blen[i]     = 30;
      corr_en[i]  = 1'b0;
      corr_val[i] = 8'h00;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    if (sel == 1) bus_b.start = 1'b1; else bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: done_wait got no done pulse, required 1 within 3000 cycles", name);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_sent(input int k);
    int n = 0;
    while (n_sent < k && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n_sent < k) begin
      n_cmp++; n_fail++;
      $display("FAIL sent_wait: got %0d sends, required %0d", n_sent, k);
    end
  endtask

  task automatic test_reset();
    logic [36:0] v;
    rst_n = 1'b0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    cfg_ideal();
    model_clear();
    repeat (3) @(negedge clk);
    v = {bus_a.busy, bus_a.done, bus_a.pass, bus_a.timeout_seen, bus_a.send_en,
         bus_a.err_cnt, bus_a.byte_cnt, bus_a.send_data};
    n_cmp++;
    if (v !== 37'd0) begin
      n_fail++; $display("FAIL reset_a: outputs %h, required 0", v);
    end
    v = {bus_b.busy, bus_b.done, bus_b.pass, bus_b.timeout_seen, bus_b.send_en,
         bus_b.err_cnt, bus_b.byte_cnt, bus_b.send_data};
    n_cmp++;
    if (v !== 37'd0) begin
      n_fail++; $display("FAIL reset_b: outputs %h, required 0", v);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ideal();
    logic [7:0] exp_b [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
    sel = 0; cfg_ideal(); model_clear();
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus_a.busy, bus_a.send_en} !== 2'b11) begin
      n_fail++; $display("FAIL start_latency: busy,send_en=%b, required 11", {bus_a.busy, bus_a.send_en});
    end
    @(negedge clk);
    bus_a.start = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bus_a.send_en !== 1'b0) begin
      n_fail++; $display("FAIL send_en_width: got %b, required 0", bus_a.send_en);
    end
    wait_done("ideal");
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (sent[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL ideal_byte%0d: got %h, required %h", i, sent[i], exp_b[i]);
      end
    end
    n_cmp++;
    if (send_cyc[1] - send_cyc[0] != 52) begin
      n_fail++; $display("FAIL ideal_spacing: got %0d, required 52", send_cyc[1] - send_cyc[0]);
    end
    n_cmp++;
    if ({n_sent[3:0], done_cnt[3:0]} !== 8'h41) begin
      n_fail++; $display("FAIL ideal_counts: sends=%0d dones=%0d, required 4 and 1", n_sent, done_cnt);
    end
    n_cmp++;
    if ({bus_a.pass, bus_a.timeout_seen, bus_a.busy, bus_a.err_cnt, bus_a.byte_cnt} !== {3'b100, 8'd0, 16'd4}) begin
      n_fail++; $display("FAIL ideal_status: pass=%b tmo=%b busy=%b err=%0d bytes=%0d, required 1 0 0 0 4",
                         bus_a.pass, bus_a.timeout_seen, bus_a.busy, bus_a.err_cnt, bus_a.byte_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_b [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    sel = 1; cfg_ideal(); model_clear();
    pulse_start();
    wait_done("wrap");
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (sent[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL wrap_byte%0d: got %h, required %h", i, sent[i], exp_b[i]);
      end
    end
    n_cmp++;
    if ({bus_b.pass, bus_b.err_cnt, bus_b.byte_cnt} !== {1'b1, 8'd0, 16'd4}) begin
      n_fail++; $display("FAIL wrap_status: pass=%b err=%0d bytes=%0d, required 1 0 4",
                         bus_b.pass, bus_b.err_cnt, bus_b.byte_cnt);
    end
    sel = 0;
  endtask

  task automatic test_corrupt();
    sel = 0; cfg_ideal(); model_clear();
    corr_en[1] = 1'b1; corr_val[1] = 8'h00;
    pulse_start();
    wait_done("corrupt");
    n_cmp++;
    if ({bus_a.pass, bus_a.timeout_seen, bus_a.err_cnt, bus_a.byte_cnt} !== {2'b00, 8'd1, 16'd4}) begin
      n_fail++; $display("FAIL corrupt_status: pass=%b tmo=%b err=%0d bytes=%0d, required 0 0 1 4",
                         bus_a.pass, bus_a.timeout_seen, bus_a.err_cnt, bus_a.byte_cnt);
    end
  endtask

  task automatic test_drop();
    sel = 0; cfg_ideal(); model_clear();
    dly[2] = 120; blen[2] = 125;
    pulse_start();
    wait_done("drop");
    n_cmp++;
    if ({bus_a.pass, bus_a.timeout_seen, bus_a.err_cnt, bus_a.byte_cnt} !== {2'b01, 8'd1, 16'd4}) begin
      n_fail++; $display("FAIL drop_status: pass=%b tmo=%b err=%0d bytes=%0d, required 0 1 1 4",
                         bus_a.pass, bus_a.timeout_seen, bus_a.err_cnt, bus_a.byte_cnt);
    end
    n_cmp++;
    if (n_sent != 4 || sent[3] !== 8'h44) begin
      n_fail++; $display("FAIL drop_fourth: sends=%0d last=%h, required 4 and 44", n_sent, sent[3]);
    end
  endtask

  task automatic test_control();
    logic [36:0] v;
    sel = 0; cfg_ideal(); model_clear();
    pulse_start();
    wait_sent(2);
    repeat (5) @(negedge clk);
    pulse_start();
    wait_done("restart");
    n_cmp++;
    if (n_sent != 4 || done_cnt != 1 || bus_a.pass !== 1'b1 || bus_a.byte_cnt !== 16'd4) begin
      n_fail++; $display("FAIL midrun_start: sends=%0d dones=%0d pass=%b bytes=%0d, required 4 1 1 4",
                         n_sent, done_cnt, bus_a.pass, bus_a.byte_cnt);
    end
    model_clear();
    pulse_start();
    wait_sent(2);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    v = {bus_a.busy, bus_a.done, bus_a.pass, bus_a.timeout_seen, bus_a.send_en,
         bus_a.err_cnt, bus_a.byte_cnt, bus_a.send_data};
    n_cmp++;
    if (v !== 37'd0) begin
      n_fail++; $display("FAIL midrun_reset: outputs %h, required 0", v);
    end
    repeat (80) @(negedge clk);
    n_cmp++;
    if (done_cnt != 0) begin
      n_fail++; $display("FAIL reset_no_done: dones=%0d, required 0", done_cnt);
    end
    rst_n = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    pulse_start();
    wait_done("after_reset");
    n_cmp++;
    if ({bus_a.pass, bus_a.err_cnt, bus_a.byte_cnt, n_sent[3:0]} !== {1'b1, 8'd0, 16'd4, 4'd4}) begin
      n_fail++; $display("FAIL after_reset: pass=%b err=%0d bytes=%0d sends=%0d, required 1 0 4 4",
                         bus_a.pass, bus_a.err_cnt, bus_a.byte_cnt, n_sent);
    end
  endtask

  task automatic test_boundary();
    sel = 0; cfg_ideal(); model_clear();
    dly[0] = 100;
    pulse_start();
    wait_done("edge_echo");
    n_cmp++;
    if ({bus_a.pass, bus_a.timeout_seen, bus_a.err_cnt} !== {2'b10, 8'd0}) begin
      n_fail++; $display("FAIL edge_echo: pass=%b tmo=%b err=%0d, required 1 0 0",
                         bus_a.pass, bus_a.timeout_seen, bus_a.err_cnt);
    end
    cfg_ideal(); model_clear();
    dly[0] = 101;
    pulse_start();
    wait_done("edge_late");
    n_cmp++;
    if ({bus_a.pass, bus_a.timeout_seen, bus_a.err_cnt, bus_a.byte_cnt} !== {2'b01, 8'd1, 16'd4}) begin
      n_fail++; $display("FAIL edge_late: pass=%b tmo=%b err=%0d bytes=%0d, required 0 1 1 4",
                         bus_a.pass, bus_a.timeout_seen, bus_a.err_cnt, bus_a.byte_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_wrap();
    test_corrupt();
    test_drop();
    test_control();
    test_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
